// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and parity helper.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } uart_state_e;

   // Framing options captured at start-bit detection.
   typedef struct packed {
      logic two_stop;
      logic parity_en;
      logic parity_even;
   } uart_frame_cfg_t;

   // Parity bit that makes the frame's parity even (even=1) or odd (even=0).
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic even);
      return even ? (^data) : ~(^data);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs; both flops preset to 1 (idle-high lines, buttons).
module uart_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic synced
);

   logic meta;

   // Metastability filter chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b1;
         synced <= 1'b1;
      end else begin
         meta   <= raw;
         synced <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, 1 or 2 stop bits, mid-bit sampling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_DIVIDER_WIDTH = 16
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           serial_i,
   input  logic                           two_stop_bits_i,
   input  logic                           parity_bit_i,
   input  logic                           parity_even_i,
   input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
   output logic [DATA_BITS-1:0]           data_o,
   output logic                           data_valid_o,
   output logic                           parity_error_o,
   output logic                           framing_error_o,
   output logic                           busy_o
);

   localparam int unsigned CW = CLOCK_DIVIDER_WIDTH;

   logic rx;

   uart_state_e            state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [CW-1:0]          div, div_nxt;
   uart_frame_cfg_t        cfg, cfg_nxt;
   logic [BIT_IDX_W-1:0]   idx, idx_nxt;
   logic [DATA_BITS-1:0]   shift, shift_nxt;
   logic                   perr, perr_nxt;
   logic                   ferr, ferr_nxt;
   logic                   armed, armed_nxt;
   logic [DATA_BITS-1:0]   data_nxt;
   logic                   valid_nxt;
   logic                   perr_out_nxt;
   logic                   ferr_out_nxt;
   logic                   busy_nxt;
   logic                   tick;
   logic                   done;

   // Bring the serial line into the clock domain.
   uart_sync u_sync (
      .clk    (clock_i),
      .rst_n  (reset_i),
      .raw    (serial_i),
      .synced (rx)
   );

   // Next-state, bit timing, data capture and status generation.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      div_nxt      = div;
      cfg_nxt      = cfg;
      idx_nxt      = idx;
      shift_nxt    = shift;
      perr_nxt     = perr;
      ferr_nxt     = ferr;
      armed_nxt    = armed;
      data_nxt     = data_o;
      valid_nxt    = 1'b0;
      perr_out_nxt = parity_error_o;
      ferr_out_nxt = framing_error_o;
      done         = 1'b0;
      tick         = (cnt == '0);

      // Free-running down-counter while a frame is in flight; reload one bit period on each sample.
      if (state != ST_IDLE) begin
         cnt_nxt = tick ? (div - CW'(1)) : (cnt - CW'(1));
      end

      case (state)
         ST_IDLE: begin
            if (rx) begin
               armed_nxt = 1'b1;
            end else if (armed) begin
               state_nxt           = ST_START;
               div_nxt             = clock_divider_i;
               cfg_nxt.two_stop    = two_stop_bits_i;
               cfg_nxt.parity_en   = parity_bit_i;
               cfg_nxt.parity_even = parity_even_i;
               // Half a bit period lands the first sample in the middle of the start bit.
               cnt_nxt             = (clock_divider_i >> 1) - CW'(1);
               perr_nxt            = 1'b0;
               ferr_nxt            = 1'b0;
            end
         end

         ST_START: begin
            if (tick) begin
               if (rx) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_DATA;
                  idx_nxt   = '0;
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               shift_nxt[idx] = rx;
               idx_nxt        = idx + BIT_IDX_W'(1);
               if (idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                  state_nxt = cfg.parity_en ? ST_PARITY : ST_STOP1;
               end
            end
         end

         ST_PARITY: begin
            if (tick) begin
               perr_nxt  = (rx != parity_bit(shift, cfg.parity_even));
               state_nxt = ST_STOP1;
            end
         end

         ST_STOP1: begin
            if (tick) begin
               ferr_nxt = ferr | ~rx;
               if (cfg.two_stop) begin
                  state_nxt = ST_STOP2;
               end else begin
                  done = 1'b1;
               end
            end
         end

         ST_STOP2: begin
            if (tick) begin
               ferr_nxt = ferr | ~rx;
               done     = 1'b1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Frame completion: publish results and return to IDLE while still inside the stop bit.
      if (done) begin
         state_nxt    = ST_IDLE;
         valid_nxt    = 1'b1;
         data_nxt     = shift;
         perr_out_nxt = perr;
         ferr_out_nxt = ferr_nxt;
         // A bad stop bit means the line may be held low; require it to go idle before re-arming.
         armed_nxt    = ~ferr_nxt;
      end

      busy_nxt = (state_nxt != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         div             <= '0;
         cfg             <= '0;
         idx             <= '0;
         shift           <= '0;
         perr            <= 1'b0;
         ferr            <= 1'b0;
         armed           <= 1'b1;
         data_o          <= '0;
         data_valid_o    <= 1'b0;
         parity_error_o  <= 1'b0;
         framing_error_o <= 1'b0;
         busy_o          <= 1'b0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         div             <= div_nxt;
         cfg             <= cfg_nxt;
         idx             <= idx_nxt;
         shift           <= shift_nxt;
         perr            <= perr_nxt;
         ferr            <= ferr_nxt;
         armed           <= armed_nxt;
         data_o          <= data_nxt;
         data_valid_o    <= valid_nxt;
         parity_error_o  <= perr_out_nxt;
         framing_error_o <= ferr_out_nxt;
         busy_o          <= busy_nxt;
      end
   end

endmodule
